// File: rtl/pipeexe_mc.sv
// Pipelined EXE stage: ALU, jump-and-link and optional multi-cycle multiply into an EX/MEM register.
// Latency: ALU/JAL results 1 cycle; multiply WIDTH+2 cycles from issue to result.
// Backpressure: estall (combinational) holds the upstream instruction for the whole multiply.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   ein_valid         EXE instruction valid
//   ealuc             ALU op code
//   ealuimm/eshift    B = eimm / A = zero-extended esa
//   ejal/emul         jump-and-link (wins over emul) / multiply
//   epc4              PC+4 of the instruction (PC_W bits)
//   ea, eb, eimm      operands and extended immediate (WIDTH bits)
//   esa, ern0         shift amount, destination register
//   estall            upstream must hold inputs while 1
//   mvalid, mrn, malu registered EX/MEM result
//
// Build option: define PIPEEXE_MUL_EN to include the shift-add multiplier and its
// MUL/DONE states; without it emul is ignored and estall is constant 0.
module pipeexe_mc #(
  parameter int WIDTH = 32,
  parameter int PC_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ein_valid,
  input  logic [3:0]       ealuc,
  input  logic             ealuimm,
  input  logic             eshift,
  input  logic             ejal,
  input  logic             emul,
  input  logic [PC_W-1:0]  epc4,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic [WIDTH-1:0] eimm,
  input  logic [4:0]       esa,
  input  logic [4:0]       ern0,
  output logic             estall,
  output logic             mvalid,
  output logic [4:0]       mrn,
  output logic [WIDTH-1:0] malu
);

  logic [WIDTH-1:0] opa, opb, alu_r, pcx, exe_res;
  logic [4:0]       exe_rn;
  logic [5:0]       sh6;
  logic             big;

  assign opa = eshift ? {{(WIDTH-5){1'b0}}, esa} : ea;
  assign opb = ealuimm ? eimm : eb;

  always_comb begin
    pcx = '0;
    pcx[PC_W-1:0] = epc4;
  end

  // Shift amount comes from A[4:0]; for WIDTH=16 it can reach or exceed WIDTH.
  assign sh6 = {1'b0, opa[4:0]};
  assign big = (sh6 >= 6'(WIDTH));

  always_comb begin
    alu_r = '0;
    case (ealuc[2:0])
      3'b000: alu_r = opa + opb;
      3'b100: alu_r = opa - opb;
      3'b001: alu_r = opa & opb;
      3'b101: alu_r = opa | opb;
      3'b010: alu_r = opa ^ opb;
      3'b110: alu_r = opb << (WIDTH/2);
      default: begin
        if (ealuc[3:2] == 2'b11)
          alu_r = big ? {WIDTH{opb[WIDTH-1]}} : WIDTH'($signed(opb) >>> opa[4:0]);
        else if (ealuc[2])
          alu_r = big ? '0 : (opb >> opa[4:0]);
        else
          alu_r = big ? '0 : (opb << opa[4:0]);
      end
    endcase
  end

  assign exe_res = ejal ? (pcx + WIDTH'(4)) : alu_r;
  assign exe_rn  = ejal ? 5'd31 : ern0;

`ifdef PIPEEXE_MUL_EN
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ma, mb, acc;
  logic             start;

  assign start  = ein_valid && emul && !ejal;
  assign estall = !reset && (((state == IDLE) && start) || (state == MUL));

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      mvalid <= 1'b0;
      mrn    <= '0;
      malu   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= MUL;
            ma     <= opa;
            mb     <= opb;
            acc    <= '0;
            cnt    <= CW'(WIDTH-1);
            mvalid <= 1'b0;
          end else if (ein_valid) begin
            mvalid <= 1'b1;
            mrn    <= exe_rn;
            malu   <= exe_res;
          end else begin
            mvalid <= 1'b0;
          end
        end
        MUL: begin
          // Multiplicand shifts left, multiplier right; only the low WIDTH bits are kept.
          acc    <= acc + (mb[0] ? ma : '0);
          ma     <= ma << 1;
          mb     <= mb >> 1;
          mvalid <= 1'b0;
          if (cnt == '0)
            state <= DONE;
          else
            cnt <= cnt - CW'(1);
        end
        DONE: begin
          malu   <= acc;
          mrn    <= ern0;
          mvalid <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_emul;
  assign unused_emul = emul;
  assign estall      = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      mvalid <= 1'b0;
      mrn    <= '0;
      malu   <= '0;
    end else if (ein_valid) begin
      mvalid <= 1'b1;
      mrn    <= exe_rn;
      malu   <= exe_res;
    end else begin
      mvalid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipeexe_mc.sv
module tb_pipeexe_mc;
  localparam int W  = 32;
  localparam int PW = 8;
`ifdef PIPEEXE_MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          ein_valid;
  logic [3:0]    ealuc;
  logic          ealuimm, eshift, ejal, emul;
  logic [PW-1:0] epc4;
  logic [W-1:0]  ea, eb, eimm;
  logic [4:0]    esa, ern0;
  logic          estall, mvalid;
  logic [4:0]    mrn;
  logic [W-1:0]  malu;

  pipeexe_mc #(.WIDTH(W), .PC_W(PW)) dut (
    .clock(clock), .reset(reset), .ein_valid(ein_valid), .ealuc(ealuc),
    .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal), .emul(emul), .epc4(epc4),
    .ea(ea), .eb(eb), .eimm(eimm), .esa(esa), .ern0(ern0),
    .estall(estall), .mvalid(mvalid), .mrn(mrn), .malu(malu)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]   rn;
    logic [W-1:0] alu;
  } res_t;

  res_t sbq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: shifts are done bit by bit.
  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    int sh;
    sh = int'(a[4:0]);
    r  = b;
    case (op[2:0])
      3'b000: return a + b;
      3'b100: return a - b;
      3'b001: return a & b;
      3'b101: return a | b;
      3'b010: return a ^ b;
      3'b110: return {b[W/2-1:0], {(W/2){1'b0}}};
      default: begin
        for (int i = 0; i < sh; i++) begin
          if (op == 4'b1111)      r = {r[W-1], r[W-1:1]};
          else if (op == 4'b0111) r = {1'b0, r[W-1:1]};
          else                    r = {r[W-2:0], 1'b0};
        end
        return r;
      end
    endcase
  endfunction

  function automatic res_t model(input logic [3:0] op, input logic imm, input logic shift,
                                 input logic jal, input logic mul, input logic [PW-1:0] pc,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] im, input logic [4:0] sa,
                                 input logic [4:0] rn);
    res_t r;
    logic [W-1:0] oa, ob;
    logic [63:0]  p;
    oa = shift ? W'(sa) : a;
    ob = imm ? im : b;
    r.rn = rn;
    if (jal) begin
      r.rn  = 5'd31;
      r.alu = W'(pc) + W'(4);
    end else if (MULEN && mul) begin
      p     = 64'(oa) * 64'(ob);
      r.alu = p[W-1:0];
    end else begin
      r.alu = alu_ref(op, oa, ob);
    end
    return r;
  endfunction

  // Result monitor: every cycle with mvalid=1 retires one scoreboard entry.
  always @(negedge clock) begin
    res_t e;
    if (reset === 1'b0 && mvalid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result", 64'(mvalid), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("mrn", 64'(mrn), 64'(e.rn));
        chk("malu", 64'(malu), 64'(e.alu));
      end
    end
  end

  // Called just after a rising edge; holds the instruction until an edge with estall=0.
  task automatic issue(input logic [3:0] op, input logic imm, input logic shift,
                       input logic jal, input logic mul, input logic [PW-1:0] pc,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] im, input logic [4:0] sa,
                       input logic [4:0] rn, input bit scramble);
    int  nst;
    int  exp_st;
    bit  done;
    ealuc = op; ealuimm = imm; eshift = shift; ejal = jal; emul = mul; epc4 = pc;
    ea = a; eb = b; eimm = im; esa = sa; ern0 = rn; ein_valid = 1'b1;
    sbq.push_back(model(op, imm, shift, jal, mul, pc, a, b, im, sa, rn));
    exp_st = (MULEN && mul && !jal) ? W + 1 : 0;
    nst  = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (estall === 1'b1) nst++;
      else done = 1'b1;
      @(posedge clock); #1;
      if (scramble && !done) begin
        ea = $urandom;
        eb = $urandom;
      end
    end
    chk("consumed", 64'(done), 64'd1);
    chk("stall_cycles", 64'(nst), 64'(exp_st));
    ein_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ein_valid = 1'b1; emul = 1'b1; ejal = 1'b0; ealuc = 4'b0000;
    ealuimm = 1'b0; eshift = 1'b0; epc4 = '0; ea = 32'd3; eb = 32'd4; eimm = '0;
    esa = '0; ern0 = 5'd1;
    @(negedge clock);
    chk("estall_in_reset", 64'(estall), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; ein_valid = 1'b0; emul = 1'b0;
    @(negedge clock);
    chk("rst_mvalid", 64'(mvalid), 64'd0);
    chk("rst_mrn", 64'(mrn), 64'd0);
    chk("rst_malu", 64'(malu), 64'd0);
    chk("rst_estall", 64'(estall), 64'd0);
    @(posedge clock); #1;

    // add, then idle: outputs hold
    issue(4'b0000, 0, 0, 0, 0, 8'h00, 32'd5, 32'd7, 32'd0, 5'd0, 5'd3, 0);
    repeat (2) @(negedge clock);
    chk("idle_mvalid", 64'(mvalid), 64'd0);
    chk("idle_hold_malu", 64'(malu), 64'd12);
    chk("idle_hold_mrn", 64'(mrn), 64'd3);
    @(posedge clock); #1;

    // back-to-back ALU ops
    issue(4'b0100, 0, 0, 0, 0, 8'h00, 32'd0, 32'd1, 32'd0, 5'd0, 5'd4, 0);
    issue(4'b0001, 0, 0, 0, 0, 8'h00, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 5'd0, 5'd6, 0);
    issue(4'b0101, 0, 0, 0, 0, 8'h00, 32'hF0F0_1234, 32'h0FF0_0001, 32'd0, 5'd0, 5'd6, 0);
    issue(4'b1010, 0, 0, 0, 0, 8'h00, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 5'd0, 5'd8, 0);
    issue(4'b0110, 1, 0, 0, 0, 8'h00, 32'd0, 32'd9, 32'h0000_ABCD, 5'd0, 5'd7, 0);
    issue(4'b0011, 0, 1, 0, 0, 8'h00, 32'd0, 32'd3, 32'd0, 5'd31, 5'd10, 0);
    issue(4'b0111, 0, 1, 0, 0, 8'h00, 32'd0, 32'h8000_0000, 32'd0, 5'd8, 5'd11, 0);
    issue(4'b1111, 0, 1, 0, 0, 8'h00, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 5'd12, 0);
    issue(4'b1111, 0, 0, 0, 0, 8'h00, 32'h0000_0023, 32'h8000_1000, 32'd0, 5'd0, 5'd13, 0);
    issue(4'b1000, 1, 0, 0, 0, 8'h00, 32'hFFFF_FFFF, 32'd0, 32'd2, 5'd0, 5'd14, 0);
    // jal beats emul
    issue(4'b0000, 0, 0, 1, 1, 8'hFC, 32'd1, 32'd2, 32'd0, 5'd0, 5'd5, 0);

    // multiply (ALU add when the multiplier is not built)
    issue(4'b0000, 0, 0, 0, 1, 8'h00, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 5'd0, 5'd9, 0);
    for (int k = 0; k < 3; k++)
      issue(4'b0000, 0, 0, 0, 1, 8'h00, $urandom, $urandom, 32'd0, 5'd0, 5'(15 + k), 1);
    issue(4'b0100, 0, 0, 0, 0, 8'h00, 32'd100, 32'd1, 32'd0, 5'd0, 5'd2, 0);

    // emul without ein_valid does nothing
    emul = 1'b1; ejal = 1'b0; ein_valid = 1'b0;
    @(negedge clock);
    chk("novalid_estall", 64'(estall), 64'd0);
    @(negedge clock);
    chk("novalid_mvalid", 64'(mvalid), 64'd0);
    emul = 1'b0;
    @(posedge clock); #1;

`ifdef PIPEEXE_MUL_EN
    // reset in the 10th MUL cycle discards the multiply
    ealuc = 4'b0000; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0; emul = 1'b1;
    ea = 32'h0000_FFFF; eb = 32'h0001_0001; ern0 = 5'd9; ein_valid = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("midmul_estall_in_reset", 64'(estall), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0; ein_valid = 1'b0; emul = 1'b0;
    @(negedge clock);
    chk("midmul_estall", 64'(estall), 64'd0);
    chk("midmul_mvalid", 64'(mvalid), 64'd0);
    chk("midmul_malu", 64'(malu), 64'd0);
    @(posedge clock); #1;
    issue(4'b0000, 0, 0, 0, 0, 8'h00, 32'd20, 32'd22, 32'd0, 5'd0, 5'd1, 0);
`endif

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
